// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Purpose:
//   Sits behind a UART receiver and hunts for framed packets of the form
//     SYNC, LEN, PAYLOAD[LEN], CSUM
//   Payload bytes are forwarded as a registered stream with first/last
//   markers. Each frame ends with a frame_done pulse whose frame_ok qualifier
//   reports the result:
//     1 = checksum good
//     0 = checksum mismatch, oversize length or inter-byte timeout
//   The checksum covers LEN, the payload and CSUM. It is good when the
//   modulo-256 sum of those bytes is zero.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_data    in   8  received byte
//   in_valid   in   1  one-cycle strobe qualifying in_data (no backpressure)
//   out_data   out  8  forwarded payload byte
//   out_valid  out  1  one-cycle strobe per payload byte
//   out_first  out  1  with out_valid: first payload byte of the frame
//   out_last   out  1  with out_valid: final payload byte of the frame
//   frame_done out  1  one-cycle pulse at frame end or abort
//   frame_ok   out  1  with frame_done: 1 = good frame, 0 = error/abort
//   err_count  out  8  saturating count of failed/aborted frames
// -----------------------------------------------------------------------------
module uart_frame_parser #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  MAX_LEN = 8'd64,
  parameter logic [31:0] TIMEOUT = 32'd4340
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_first,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_reg,      state_next;
  logic [7:0]  remaining_reg,  remaining_next;
  logic [7:0]  sum_reg,        sum_next;
  logic [31:0] timer_reg,      timer_next;
  logic        first_reg,      first_next;

  logic [7:0]  out_data_reg,   out_data_next;
  logic        out_valid_reg,  out_valid_next;
  logic        out_first_reg,  out_first_next;
  logic        out_last_reg,   out_last_next;
  logic        done_reg,       done_next;
  logic        ok_reg,         ok_next;
  logic [7:0]  err_reg,        err_next;

  logic        err_inc;
  logic        timer_expired;
  logic [7:0]  sum_with_byte;

  // Running sum including the byte currently on the input. In CSUM this is
  // the full frame total that must come out as zero.
  assign sum_with_byte = sum_reg + in_data;

  // A byte arriving in the same cycle the timer sits at TIMEOUT takes
  // priority. Only a silent cycle at the limit aborts the frame.
  assign timer_expired = (state_reg != ST_IDLE) && !in_valid &&
                         (timer_reg == TIMEOUT);

  // ---------------------------------------------------------------------------
  // Inter-byte timer: held at zero while hunting, cleared by every byte,
  // otherwise counts idle cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_next = timer_reg;
    if (state_reg == ST_IDLE || in_valid) begin
      timer_next = 32'd0;
    end else if (timer_reg != TIMEOUT) begin
      timer_next = timer_reg + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and output pulse generation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    sum_next       = sum_reg;
    first_next     = first_reg;

    // Hold the data bus. The pulse outputs default low every cycle.
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    out_first_next = 1'b0;
    out_last_next  = 1'b0;
    done_next      = 1'b0;
    ok_next        = 1'b0;
    err_inc        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Anything other than SYNC is noise between frames.
        if (in_valid && in_data == SYNC) begin
          state_next = ST_LEN;
        end
      end

      ST_LEN: begin
        // A SYNC value here is a length like any other; no resync.
        if (in_valid) begin
          remaining_next = in_data;
          sum_next       = in_data;
          first_next     = 1'b1;
          if (in_data == 8'd0) begin
            state_next = ST_CSUM;
          end else if (in_data > MAX_LEN) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            err_inc    = 1'b1;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (in_valid) begin
          out_data_next  = in_data;
          out_valid_next = 1'b1;
          out_first_next = first_reg;
          out_last_next  = (remaining_reg == 8'd1);
          first_next     = 1'b0;
          sum_next       = sum_with_byte;
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) begin
            state_next = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        // The checksum byte itself is consumed here and never forwarded.
        if (in_valid) begin
          done_next  = 1'b1;
          ok_next    = (sum_with_byte == 8'd0);
          err_inc    = (sum_with_byte != 8'd0);
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Timeout abort. It cannot coincide with a byte, so it never competes
    // with the per-state decisions above.
    if (timer_expired) begin
      state_next = ST_IDLE;
      done_next  = 1'b1;
      ok_next    = 1'b0;
      err_inc    = 1'b1;
    end
  end

  // Error counter sticks at its maximum instead of wrapping.
  always_comb begin
    err_next = err_reg;
    if (err_inc && err_reg != 8'hFF) begin
      err_next = err_reg + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= 8'd0;
      sum_reg       <= 8'd0;
      timer_reg     <= 32'd0;
      first_reg     <= 1'b0;
      out_data_reg  <= 8'd0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      ok_reg        <= 1'b0;
      err_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      sum_reg       <= sum_next;
      timer_reg     <= timer_next;
      first_reg     <= first_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_first_reg <= out_first_next;
      out_last_reg  <= out_last_next;
      done_reg      <= done_next;
      ok_reg        <= ok_next;
      err_reg       <= err_next;
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign out_first  = out_first_reg;
  assign out_last   = out_last_reg;
  assign frame_done = done_reg;
  assign frame_ok   = ok_reg;
  assign err_count  = err_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Directed testbench for uart_frame_parser.
//
// Inputs change on the falling edge. After each driven cycle the outputs
// are sampled on the next falling edge, where they reflect the byte that
// was just clocked in.
//
// Observed and expected values are compared as a packed vector:
//   {out_valid, out_first, out_last, data, frame_done, frame_ok}
// The data field is masked to zero when out_valid is low.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

  localparam int TIMEOUT = 4340;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic       frame_done;
  logic       frame_ok;
  logic [7:0] err_count;

  int tests_run;
  int tests_failed;

  uart_frame_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit, in case the bench itself misbehaves.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [12:0] ex(input logic v, input logic f,
                                     input logic l, input logic [7:0] d,
                                     input logic done, input logic ok);
    return {v, f, l, d, done, ok};
  endfunction

  function automatic logic [12:0] obs();
    return {out_valid, out_first, out_last,
            (out_valid ? out_data : 8'h00), frame_done, frame_ok};
  endfunction

  // Drive one cycle of input, then advance to the falling edge after it.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    if ({out_data, out_valid, out_first, out_last, frame_done, frame_ok,
         err_count} !== 21'd0) begin
      $display("FAIL reset_outputs: got data=%h v=%b f=%b l=%b done=%b ok=%b err=%0d, want all zero",
               out_data, out_valid, out_first, out_last, frame_done,
               frame_ok, err_count);
      tests_failed++;
    end
    tests_run++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [7:0]  b [6];
    logic [12:0] e [6];
    int pulses;
    b = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    e[0] = ex(0, 0, 0, 8'h00, 0, 0);
    e[1] = ex(0, 0, 0, 8'h00, 0, 0);
    e[2] = ex(1, 1, 0, 8'h10, 0, 0);
    e[3] = ex(1, 0, 0, 8'h20, 0, 0);
    e[4] = ex(1, 0, 1, 8'h30, 0, 0);
    e[5] = ex(0, 0, 0, 8'h00, 1, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, b[i]);
      if (obs() !== e[i]) begin
        $display("FAIL good_frame byte%0d: got %h want %h", i, obs(), e[i]);
        tests_failed++;
      end
      tests_run++;
      // 217-cycle byte spacing: 216 idle cycles follow each byte.
      for (int k = 0; k < 216; k++) begin
        step(1'b0, 8'h00);
        if (out_valid || frame_done) pulses++;
      end
    end
    if (pulses !== 0) begin
      $display("FAIL good_frame_gaps: got %0d pulses in idle gaps, want 0", pulses);
      tests_failed++;
    end
    tests_run++;
    if (err_count !== 8'd0) begin
      $display("FAIL good_frame_err: got %0d want 0", err_count);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_bad_checksum();
    logic [7:0]  b [5];
    logic [12:0] e [5];
    b = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    e[0] = ex(0, 0, 0, 8'h00, 0, 0);
    e[1] = ex(0, 0, 0, 8'h00, 0, 0);
    e[2] = ex(1, 1, 0, 8'h01, 0, 0);
    e[3] = ex(1, 0, 1, 8'h02, 0, 0);
    e[4] = ex(0, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, b[i]);
      if (obs() !== e[i]) begin
        $display("FAIL bad_csum byte%0d: got %h want %h", i, obs(), e[i]);
        tests_failed++;
      end
      tests_run++;
    end
    if (err_count !== 8'd1) begin
      $display("FAIL bad_csum_err: got %0d want 1", err_count);
      tests_failed++;
    end
    tests_run++;
  endtask

  // Zero-length frame, then a one-byte frame, all on consecutive cycles.
  // Second frame checksum: 0x01 + 0x7F = 0x80, so CSUM = 0x80.
  task automatic test_back_to_back();
    logic [7:0]  b [7];
    logic [12:0] e [7];
    b = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h80};
    e[0] = ex(0, 0, 0, 8'h00, 0, 0);
    e[1] = ex(0, 0, 0, 8'h00, 0, 0);
    e[2] = ex(0, 0, 0, 8'h00, 1, 1);
    e[3] = ex(0, 0, 0, 8'h00, 0, 0);
    e[4] = ex(0, 0, 0, 8'h00, 0, 0);
    e[5] = ex(1, 1, 1, 8'h7F, 0, 0);
    e[6] = ex(0, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, b[i]);
      if (obs() !== e[i]) begin
        $display("FAIL back_to_back byte%0d: got %h want %h", i, obs(), e[i]);
        tests_failed++;
      end
      tests_run++;
    end
    if (err_count !== 8'd1) begin
      $display("FAIL back_to_back_err: got %0d want 1", err_count);
      tests_failed++;
    end
    tests_run++;
  endtask

  // 0x55 is noise; LEN 0x41 (65) exceeds the limit and aborts. The next
  // frame: 0x01 + 0x33 = 0x34, so CSUM = 0xCC.
  task automatic test_oversize();
    logic [7:0]  b [7];
    logic [12:0] e [7];
    b = '{8'h55, 8'hA5, 8'h41, 8'hA5, 8'h01, 8'h33, 8'hCC};
    e[0] = ex(0, 0, 0, 8'h00, 0, 0);
    e[1] = ex(0, 0, 0, 8'h00, 0, 0);
    e[2] = ex(0, 0, 0, 8'h00, 1, 0);
    e[3] = ex(0, 0, 0, 8'h00, 0, 0);
    e[4] = ex(0, 0, 0, 8'h00, 0, 0);
    e[5] = ex(1, 1, 1, 8'h33, 0, 0);
    e[6] = ex(0, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, b[i]);
      if (obs() !== e[i]) begin
        $display("FAIL oversize byte%0d: got %h want %h", i, obs(), e[i]);
        tests_failed++;
      end
      tests_run++;
    end
    if (err_count !== 8'd2) begin
      $display("FAIL oversize_err: got %0d want 2", err_count);
      tests_failed++;
    end
    tests_run++;
  endtask

  // LEN = 64 is the largest accepted length. The payload is 0..63.
  // Sum = 0x40 + 2016 = 0x820, which is 0x20 mod 256, so CSUM = 0xE0.
  task automatic test_max_len();
    int valids;
    int firsts;
    int lasts;
    logic last_on_final;
    valids = 0;
    firsts = 0;
    lasts  = 0;
    last_on_final = 1'b0;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h40);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i));
      if (out_valid) valids++;
      if (out_valid && out_first) firsts++;
      if (out_valid && out_last) begin
        lasts++;
        if (i == 63 && out_data == 8'd63) last_on_final = 1'b1;
      end
    end
    if ({valids, firsts, lasts, last_on_final} !== {32'd64, 32'd1, 32'd1, 1'b1}) begin
      $display("FAIL max_len_stream: got valids=%0d firsts=%0d lasts=%0d last_ok=%b want 64/1/1/1",
               valids, firsts, lasts, last_on_final);
      tests_failed++;
    end
    tests_run++;
    step(1'b1, 8'hE0);
    if (obs() !== ex(0, 0, 0, 8'h00, 1, 1)) begin
      $display("FAIL max_len_done: got %h want %h", obs(), ex(0, 0, 0, 8'h00, 1, 1));
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_timeout();
    int early;
    // Silent frame: the timer reaches TIMEOUT after TIMEOUT idle cycles,
    // and the following silent cycle aborts the frame.
    early = 0;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    step(1'b1, 8'h11);
    for (int k = 0; k < TIMEOUT; k++) begin
      step(1'b0, 8'h00);
      if (frame_done) early++;
    end
    if (early !== 0) begin
      $display("FAIL timeout_early: got %0d frame_done pulses before limit, want 0", early);
      tests_failed++;
    end
    tests_run++;
    step(1'b0, 8'h00);
    if (obs() !== ex(0, 0, 0, 8'h00, 1, 0)) begin
      $display("FAIL timeout_abort: got %h want %h", obs(), ex(0, 0, 0, 8'h00, 1, 0));
      tests_failed++;
    end
    tests_run++;
    if (err_count !== 8'd3) begin
      $display("FAIL timeout_err: got %0d want 3", err_count);
      tests_failed++;
    end
    tests_run++;

    // Same silence, but a byte lands on the cycle the timer is at the limit.
    // Sum 0x02 + 0x11 + 0x22 = 0x35, so CSUM = 0xCB.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    step(1'b1, 8'h11);
    for (int k = 0; k < TIMEOUT; k++) step(1'b0, 8'h00);
    step(1'b1, 8'h22);
    if (obs() !== ex(1, 0, 1, 8'h22, 0, 0)) begin
      $display("FAIL timeout_byte_wins: got %h want %h", obs(), ex(1, 0, 1, 8'h22, 0, 0));
      tests_failed++;
    end
    tests_run++;
    step(1'b1, 8'hCB);
    if (obs() !== ex(0, 0, 0, 8'h00, 1, 1) || err_count !== 8'd3) begin
      $display("FAIL timeout_byte_wins_done: got %h err=%0d want %h err=3",
               obs(), err_count, ex(0, 0, 0, 8'h00, 1, 1));
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_async_reset();
    int dones;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    step(1'b1, 8'h01);
    // out_valid is high here; reset must clear it without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    if ({out_data, out_valid, out_first, out_last, frame_done, frame_ok,
         err_count} !== 21'd0) begin
      $display("FAIL async_reset: got data=%h v=%b done=%b ok=%b err=%0d, want all zero",
               out_data, out_valid, frame_done, frame_ok, err_count);
      tests_failed++;
    end
    tests_run++;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (frame_done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00);
      if (frame_done) dones++;
    end
    if (dones !== 0) begin
      $display("FAIL async_reset_no_done: got %0d pulses want 0", dones);
      tests_failed++;
    end
    tests_run++;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'h33);
    if (obs() !== ex(1, 1, 1, 8'h33, 0, 0)) begin
      $display("FAIL after_reset_payload: got %h want %h", obs(), ex(1, 1, 1, 8'h33, 0, 0));
      tests_failed++;
    end
    tests_run++;
    step(1'b1, 8'hCC);
    if (obs() !== ex(0, 0, 0, 8'h00, 1, 1) || err_count !== 8'd0) begin
      $display("FAIL after_reset_done: got %h err=%0d want %h err=0",
               obs(), err_count, ex(0, 0, 0, 8'h00, 1, 1));
      tests_failed++;
    end
    tests_run++;
  endtask

  // Frames A5 00 01 always fail (sum 0x01). 255 of them bring the count
  // from 0 to 255, and one more must leave it there.
  task automatic test_err_saturation();
    for (int n = 0; n < 255; n++) begin
      step(1'b1, 8'hA5);
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
    end
    if (err_count !== 8'd255) begin
      $display("FAIL err_reach_255: got %0d want 255", err_count);
      tests_failed++;
    end
    tests_run++;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    if (obs() !== ex(0, 0, 0, 8'h00, 1, 0) || err_count !== 8'd255) begin
      $display("FAIL err_saturate: got %h err=%0d want %h err=255",
               obs(), err_count, ex(0, 0, 0, 8'h00, 1, 0));
      tests_failed++;
    end
    tests_run++;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_back_to_back();
    test_oversize();
    test_max_len();
    test_timeout();
    test_async_reset();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
